rv32i_decoder: RTL and testbench

- Instruction decoder for the RV32I base integer ISA. Sits between instruction fetch and register-file read / execute.
- Classifies a 32-bit instruction word by format (R/I/S/B/U/J) and by specific instruction.
- Extracts register indices and builds the sign-extended immediate.
- Decode logic is combinational; all outputs are registered with one cycle of latency.

---
 rtl/rv32i_decoder.sv | 226 ++++++++++++++++++++++
 tb/tb_rv32i_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decoder.sv
// RV32I instruction decoder: combinational classify/extract, one-cycle registered outputs.
// Optional macro RV32I_DEC_SYSTEM_EN enables FENCE, ECALL and EBREAK decode.
module rv32i_decoder #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd,
  output logic [XLEN-1:0] imm,
  output logic [5:0]      fmt,
  output logic [5:0]      op,
  output logic            illegal
);

  typedef enum logic [5:0] {
    OP_NONE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK
  } op_e;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_zero, f7_alt;
  logic       opc_opimm, opc_load, opc_jalr, opc_fence, opc_system;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  assign opc_opimm  = (opcode == 7'b0010011);
  assign opc_load   = (opcode == 7'b0000011);
  assign opc_jalr   = (opcode == 7'b1100111);
  assign opc_fence  = (opcode == 7'b0001111);
  assign opc_system = (opcode == 7'b1110011);

  logic is_R, is_I, is_S, is_B, is_U, is_J;

  assign is_R = (opcode == 7'b0110011);
  assign is_S = (opcode == 7'b0100011);
  assign is_B = (opcode == 7'b1100011);
  assign is_U = (opcode == 7'b0110111) || (opcode == 7'b0010111);
  assign is_J = (opcode == 7'b1101111);
`ifdef RV32I_DEC_SYSTEM_EN
  assign is_I = opc_opimm || opc_load || opc_jalr || opc_fence || opc_system;
`else
  assign is_I = opc_opimm || opc_load || opc_jalr;
`endif

  logic is_LUI, is_AUIPC, is_JAL, is_JALR;
  logic is_BEQ, is_BNE, is_BLT, is_BGE, is_BLTU, is_BGEU;
  logic is_LB, is_LH, is_LW, is_LBU, is_LHU;
  logic is_SB, is_SH, is_SW;
  logic is_ADDI, is_SLTI, is_SLTIU, is_XORI, is_ORI, is_ANDI, is_SLLI, is_SRLI, is_SRAI;
  logic is_ADD, is_SUB, is_SLL, is_SLT, is_SLTU, is_XOR, is_SRL, is_SRA, is_OR, is_AND;
  logic is_FENCE, is_ECALL, is_EBREAK;

  assign is_LUI   = (opcode == 7'b0110111);
  assign is_AUIPC = (opcode == 7'b0010111);
  assign is_JAL   = is_J;
  assign is_JALR  = opc_jalr && (funct3 == 3'b000);

  assign is_BEQ  = is_B && (funct3 == 3'b000);
  assign is_BNE  = is_B && (funct3 == 3'b001);
  assign is_BLT  = is_B && (funct3 == 3'b100);
  assign is_BGE  = is_B && (funct3 == 3'b101);
  assign is_BLTU = is_B && (funct3 == 3'b110);
  assign is_BGEU = is_B && (funct3 == 3'b111);

  assign is_LB  = opc_load && (funct3 == 3'b000);
  assign is_LH  = opc_load && (funct3 == 3'b001);
  assign is_LW  = opc_load && (funct3 == 3'b010);
  assign is_LBU = opc_load && (funct3 == 3'b100);
  assign is_LHU = opc_load && (funct3 == 3'b101);

  assign is_SB = is_S && (funct3 == 3'b000);
  assign is_SH = is_S && (funct3 == 3'b001);
  assign is_SW = is_S && (funct3 == 3'b010);

  assign is_ADDI  = opc_opimm && (funct3 == 3'b000);
  assign is_SLTI  = opc_opimm && (funct3 == 3'b010);
  assign is_SLTIU = opc_opimm && (funct3 == 3'b011);
  assign is_XORI  = opc_opimm && (funct3 == 3'b100);
  assign is_ORI   = opc_opimm && (funct3 == 3'b110);
  assign is_ANDI  = opc_opimm && (funct3 == 3'b111);
  assign is_SLLI  = opc_opimm && (funct3 == 3'b001) && f7_zero;
  assign is_SRLI  = opc_opimm && (funct3 == 3'b101) && f7_zero;
  assign is_SRAI  = opc_opimm && (funct3 == 3'b101) && f7_alt;

  assign is_ADD  = is_R && (funct3 == 3'b000) && f7_zero;
  assign is_SUB  = is_R && (funct3 == 3'b000) && f7_alt;
  assign is_SLL  = is_R && (funct3 == 3'b001) && f7_zero;
  assign is_SLT  = is_R && (funct3 == 3'b010) && f7_zero;
  assign is_SLTU = is_R && (funct3 == 3'b011) && f7_zero;
  assign is_XOR  = is_R && (funct3 == 3'b100) && f7_zero;
  assign is_SRL  = is_R && (funct3 == 3'b101) && f7_zero;
  assign is_SRA  = is_R && (funct3 == 3'b101) && f7_alt;
  assign is_OR   = is_R && (funct3 == 3'b110) && f7_zero;
  assign is_AND  = is_R && (funct3 == 3'b111) && f7_zero;

`ifdef RV32I_DEC_SYSTEM_EN
  assign is_FENCE  = opc_fence && (funct3 == 3'b000);
  assign is_ECALL  = (instr == 32'h0000_0073);
  assign is_EBREAK = (instr == 32'h0010_0073);
`else
  assign is_FENCE  = 1'b0;
  assign is_ECALL  = 1'b0;
  assign is_EBREAK = 1'b0;
`endif

  op_e op_d;

  // Instruction flags are mutually exclusive, so chain order is irrelevant.
  always_comb begin
    op_d = OP_NONE;
    if      (is_LUI)    op_d = OP_LUI;
    else if (is_AUIPC)  op_d = OP_AUIPC;
    else if (is_JAL)    op_d = OP_JAL;
    else if (is_JALR)   op_d = OP_JALR;
    else if (is_BEQ)    op_d = OP_BEQ;
    else if (is_BNE)    op_d = OP_BNE;
    else if (is_BLT)    op_d = OP_BLT;
    else if (is_BGE)    op_d = OP_BGE;
    else if (is_BLTU)   op_d = OP_BLTU;
    else if (is_BGEU)   op_d = OP_BGEU;
    else if (is_LB)     op_d = OP_LB;
    else if (is_LH)     op_d = OP_LH;
    else if (is_LW)     op_d = OP_LW;
    else if (is_LBU)    op_d = OP_LBU;
    else if (is_LHU)    op_d = OP_LHU;
    else if (is_SB)     op_d = OP_SB;
    else if (is_SH)     op_d = OP_SH;
    else if (is_SW)     op_d = OP_SW;
    else if (is_ADDI)   op_d = OP_ADDI;
    else if (is_SLTI)   op_d = OP_SLTI;
    else if (is_SLTIU)  op_d = OP_SLTIU;
    else if (is_XORI)   op_d = OP_XORI;
    else if (is_ORI)    op_d = OP_ORI;
    else if (is_ANDI)   op_d = OP_ANDI;
    else if (is_SLLI)   op_d = OP_SLLI;
    else if (is_SRLI)   op_d = OP_SRLI;
    else if (is_SRAI)   op_d = OP_SRAI;
    else if (is_ADD)    op_d = OP_ADD;
    else if (is_SUB)    op_d = OP_SUB;
    else if (is_SLL)    op_d = OP_SLL;
    else if (is_SLT)    op_d = OP_SLT;
    else if (is_SLTU)   op_d = OP_SLTU;
    else if (is_XOR)    op_d = OP_XOR;
    else if (is_SRL)    op_d = OP_SRL;
    else if (is_SRA)    op_d = OP_SRA;
    else if (is_OR)     op_d = OP_OR;
    else if (is_AND)    op_d = OP_AND;
    else if (is_FENCE)  op_d = OP_FENCE;
    else if (is_ECALL)  op_d = OP_ECALL;
    else if (is_EBREAK) op_d = OP_EBREAK;
  end

  logic            legal;
  logic [5:0]      fmt_d;
  logic [XLEN-1:0] rs1_d, rs2_d, rd_d, imm_d;

  assign legal = (op_d != OP_NONE);
  assign fmt_d = {is_J, is_U, is_B, is_S, is_I, is_R};
  assign rs1_d = (is_R || is_I || is_S || is_B) ? {{(XLEN-5){1'b0}}, instr[19:15]} : '0;
  assign rs2_d = (is_R || is_S || is_B)         ? {{(XLEN-5){1'b0}}, instr[24:20]} : '0;
  assign rd_d  = (is_R || is_I || is_U || is_J) ? {{(XLEN-5){1'b0}}, instr[11:7]}  : '0;

  always_comb begin
    imm_d = '0;
    if (is_SLLI || is_SRLI || is_SRAI)
      imm_d = {{(XLEN-5){1'b0}}, instr[24:20]};
    else if (is_I)
      imm_d = {{(XLEN-12){instr[31]}}, instr[31:20]};
    else if (is_S)
      imm_d = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    else if (is_B)
      imm_d = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    else if (is_U)
      imm_d = {instr[31:12], 12'b0};
    else if (is_J)
      imm_d = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  logic [XLEN-1:0] rs1_q, rs2_q, rd_q, imm_q;
  logic [5:0]      fmt_q;
  op_e             op_q;
  logic            illegal_q;

  always_ff @(posedge clk) begin
    if (reset || !legal) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      fmt_q     <= '0;
      op_q      <= OP_NONE;
      illegal_q <= !reset;
    end else begin
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      fmt_q     <= fmt_d;
      op_q      <= op_d;
      illegal_q <= 1'b0;
    end
  end

  assign rs1     = rs1_q;
  assign rs2     = rs2_q;
  assign rd      = rd_q;
  assign imm     = imm_q;
  assign fmt     = fmt_q;
  assign op      = op_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_rv32i_decoder.sv
// Scoreboard bench for rv32i_decoder: mask/match rule-table reference model, random plus directed words.
module tb_rv32i_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] rs1, rs2, rd, imm;
  logic [5:0]  fmt, op;
  logic        illegal;

  rv32i_decoder #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .fmt(fmt), .op(op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [5:0]  op;
    logic [2:0]  fi;   // 0 R, 1 I, 2 S, 3 B, 4 U, 5 J
  } rule_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1, rs2, rd, imm;
    logic [5:0]  fmt, op;
    logic        ill;
    logic [5:0]  cfmt;
    logic [7:0]  cins;
  } exp_t;

  rule_t rules[$];
  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;

  task automatic add_rule(input logic [31:0] mask, input logic [31:0] match,
                          input int opn, input int fi);
    rule_t r;
    r.mask = mask; r.match = match; r.op = 6'(opn); r.fi = 3'(fi);
    rules.push_back(r);
  endtask

  task automatic build_rules();
    int b3[6] = '{0, 1, 4, 5, 6, 7};
    int l3[5] = '{0, 1, 2, 4, 5};
    int i3[6] = '{0, 2, 3, 4, 6, 7};
    int r3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int r7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    add_rule(32'h7F, 32'h37, 1, 4);
    add_rule(32'h7F, 32'h17, 2, 4);
    add_rule(32'h7F, 32'h6F, 3, 5);
    add_rule(32'h707F, 32'h67, 4, 1);
    for (int i = 0; i < 6; i++)  add_rule(32'h707F, 32'h63 | (b3[i] << 12), 5 + i, 3);
    for (int i = 0; i < 5; i++)  add_rule(32'h707F, 32'h03 | (l3[i] << 12), 11 + i, 1);
    for (int i = 0; i < 3; i++)  add_rule(32'h707F, 32'h23 | (i << 12), 16 + i, 2);
    for (int i = 0; i < 6; i++)  add_rule(32'h707F, 32'h13 | (i3[i] << 12), 19 + i, 1);
    add_rule(32'hFE00707F, 32'h0000_1013, 25, 1);
    add_rule(32'hFE00707F, 32'h0000_5013, 26, 1);
    add_rule(32'hFE00707F, 32'h4000_5013, 27, 1);
    for (int i = 0; i < 10; i++)
      add_rule(32'hFE00707F, 32'h33 | (r3[i] << 12) | (r7[i] << 25), 28 + i, 0);
`ifdef RV32I_DEC_SYSTEM_EN
    add_rule(32'h707F, 32'h0F, 38, 1);
    add_rule(32'hFFFFFFFF, 32'h0000_0073, 39, 1);
    add_rule(32'hFFFFFFFF, 32'h0010_0073, 40, 1);
`endif
  endtask

  function automatic logic [5:0] opcode_fmt(input logic [6:0] opc);
    case (opc)
      7'h33:                    return 6'b000001;
      7'h13, 7'h03, 7'h67:      return 6'b000010;
`ifdef RV32I_DEC_SYSTEM_EN
      7'h0F, 7'h73:             return 6'b000010;
`endif
      7'h23:                    return 6'b000100;
      7'h63:                    return 6'b001000;
      7'h37, 7'h17:             return 6'b010000;
      7'h6F:                    return 6'b100000;
      default:                  return 6'b000000;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] w, input logic rst);
    exp_t e;
    int   k = -1;
    int   o = 0;
    e = '0;
    e.instr = w;
    e.cfmt  = opcode_fmt(w[6:0]);
    for (int i = 0; i < rules.size(); i++)
      if (k < 0 && (w & rules[i].mask) == rules[i].match) k = i;
    if (k >= 0) o = int'(rules[k].op);
    e.cins = {o == 10, o == 9, o == 8, o == 7, o == 6, o == 5, o == 19, o == 28};
    if (rst) return e;
    if (k < 0) begin
      e.ill = 1'b1;
      return e;
    end
    e.op  = rules[k].op;
    e.fmt = 6'b1 << rules[k].fi;
    if (rules[k].fi inside {3'd0, 3'd1, 3'd2, 3'd3}) e.rs1 = {27'b0, w[19:15]};
    if (rules[k].fi inside {3'd0, 3'd2, 3'd3})       e.rs2 = {27'b0, w[24:20]};
    if (rules[k].fi inside {3'd0, 3'd1, 3'd4, 3'd5}) e.rd  = {27'b0, w[11:7]};
    case (rules[k].fi)
      3'd1:    e.imm = (o >= 25 && o <= 27) ? {27'b0, w[24:20]} : {{20{w[31]}}, w[31:20]};
      3'd2:    e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3:    e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    e.imm = {w[31:12], 12'b0};
      3'd5:    e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] w,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s instr=%08h got=%08h want=%08h", name, w, act, exp);
    end
  endtask

  // Monitor: outputs registered at an edge belong to the oldest queued word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rs1", e.instr, rs1, e.rs1);
        chk("rs2", e.instr, rs2, e.rs2);
        chk("rd", e.instr, rd, e.rd);
        chk("imm", e.instr, imm, e.imm);
        chk("fmt", e.instr, {26'b0, fmt}, {26'b0, e.fmt});
        chk("op", e.instr, {26'b0, op}, {26'b0, e.op});
        chk("illegal", e.instr, {31'b0, illegal}, {31'b0, e.ill});
        chk("comb_fmt", e.instr,
            {26'b0, dut.is_J, dut.is_U, dut.is_B, dut.is_S, dut.is_I, dut.is_R},
            {26'b0, e.cfmt});
        chk("comb_ins", e.instr,
            {24'b0, dut.is_BGEU, dut.is_BLTU, dut.is_BGE, dut.is_BLT,
             dut.is_BNE, dut.is_BEQ, dut.is_ADDI, dut.is_ADD},
            {24'b0, e.cins});
      end
    end
  end

  task automatic drive(input logic [31:0] w, input logic r);
    @(negedge clk);
    instr = w;
    reset = r;
    sb.push_back(model(w, r));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [31:0] rnd;
    logic [6:0]  opcs[11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73,
                              7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    int          sel = $urandom_range(0, 9);
    int          k   = $urandom_range(0, rules.size() - 1);
    rnd = $urandom;
    if (sel <= 5) begin
      w = (rnd & ~rules[k].mask) | rules[k].match;
    end else if (sel <= 7) begin
      w = {rnd[31:7], opcs[$urandom_range(0, 10)]};
    end else if (sel == 8) begin
      w = (rnd & ~rules[k].mask) | rules[k].match;
      w[$urandom_range(12, 31)] ^= 1'b1;
    end else begin
      w = rnd;
    end
    return w;
  endfunction

  initial begin
    logic [31:0] directed[$] = '{
      32'h0000_0063, 32'h0000_1063, 32'h0000_4063, 32'h0000_5063,
      32'h0000_6063, 32'h0000_7063, 32'h0000_2063, 32'h0000_3063,
      32'hFE00_0EE3, 32'hFFF1_0093, 32'h0000_0013, 32'h0020_81B3,
      32'h4020_81B3, 32'h1234_52B7, 32'h0000_0000, 32'h0000_0073,
      32'h0010_0073, 32'h0000_000F, 32'h0000_1067, 32'h0200_1013,
      32'h4000_5013, 32'h0000_5013, 32'h8000_006F, 32'hFFFF_F017,
      32'h2020_81B3, 32'h0000_3003, 32'h0000_3023, 32'hFFFF_FFFF};
    reset = 1'b1;
    instr = '0;
    build_rules();
    drive(32'h0000_0063, 1'b1);
    drive(32'h0020_81B3, 1'b1);
    foreach (directed[i]) drive(directed[i], 1'b0);
    for (int n = 0; n < 400; n++) drive(rand_word(), 1'b0);
    drive(32'h0020_81B3, 1'b0);
    drive(32'h1234_52B7, 1'b1);
    drive(32'hFFF1_0093, 1'b0);
    for (int n = 0; n < 300; n++) drive(rand_word(), ($urandom_range(0, 49) == 0));
    drive(32'h0000_0000, 1'b0);
    repeat (3) @(negedge clk);
    chk("drain", 32'h0, sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
